combi_vector_sequencer: RTL and testbench

- Sequencer for the small 4-input/3-output combinational gate datapaths (A,B,C,D -> X,Y,Z) built in this codebase.
- Holds a programmable table of input vectors and expected outputs, and applies them one at a time on a registered bus.
- Waits a programmable settle time, then samples the datapath outputs and compares them against expected.
- Reports mismatch count and first failing index, so on-chip self-check replaces hand-stepped stimulus.

---
 rtl/combi_seq_pkg.sv | 23 ++
 rtl/combi_seq_vec_ram.sv | 25 ++
 rtl/combi_vector_sequencer.sv | 142 ++++++++++++++
 tb/tb_combi_vector_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/combi_seq_pkg.sv
// Shared types and widths for the combinational vector sequencer.
// Optional response log is enabled with SEQ_RESP_LOG_EN.
package combi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    WAIT,
    DONE
  } seq_state_e;

  localparam int unsigned IN_W_DEF  = 4;
  localparam int unsigned OUT_W_DEF = 3;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/combi_seq_vec_ram.sv
// Vector/expected-response table: one write port, one async read port.
// Contents are not reset; only entries written before a run are used.
module combi_seq_vec_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 7,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // table write
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/combi_vector_sequencer.sv
// Applies table vectors to a combinational datapath and checks responses.
// Define SEQ_RESP_LOG_EN to keep a readable log of sampled responses.
module combi_vector_sequencer
  import combi_seq_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int IN_W   = IN_W_DEF,
  parameter  int OUT_W  = OUT_W_DEF,
  parameter  int SETTLE = 1,
  localparam int AW     = idx_w(DEPTH),
  localparam int CW     = cnt_w(DEPTH),
  localparam int SW     = $clog2(SETTLE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [IN_W-1:0]  cfg_vec,
  input  logic [OUT_W-1:0] cfg_exp,
  input  logic [CW-1:0]    cfg_len,
  input  logic             start,
  output logic [IN_W-1:0]  vec_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_cnt,
  output logic             first_err_vld,
  output logic [AW-1:0]    first_err_idx,
  input  logic [AW-1:0]    rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  seq_state_e state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] last_q;
  logic [SW-1:0] cnt_q;

  logic [CW-1:0] len_eff;
  logic [IN_W+OUT_W-1:0] rd_word;
  logic [IN_W-1:0] tbl_vec;
  logic [OUT_W-1:0] tbl_exp;
  logic sample;

  assign len_eff = (cfg_len > CW'(DEPTH)) ? CW'(DEPTH) : cfg_len;
  assign {tbl_vec, tbl_exp} = rd_word;
  assign sample = (state_q == WAIT) && (cnt_q == SW'(1));

  combi_seq_vec_ram #(
    .DEPTH (DEPTH),
    .W     (IN_W + OUT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (cfg_we & ~busy),
    .waddr_i (cfg_addr),
    .wdata_i ({cfg_vec, cfg_exp}),
    .raddr_i (idx_q),
    .rdata_o (rd_word)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      vec_o         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            idx_q         <= '0;
            if (len_eff == '0) begin
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              last_q  <= AW'(len_eff - CW'(1));
              busy    <= 1'b1;
              state_q <= APPLY;
            end
          end
        end
        APPLY: begin
          vec_o   <= tbl_vec;
          cnt_q   <= SW'(SETTLE);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - SW'(1);
          if (sample) begin
            if (resp_i != tbl_exp) begin
              err_cnt <= err_cnt + CW'(1);
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= idx_q;
              end
            end
            if (idx_q == last_q) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + AW'(1);
              state_q <= APPLY;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_RESP_LOG_EN
  logic [OUT_W-1:0] log_q [DEPTH];

  // capture each sampled response at its vector index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) log_q[i] <= '0;
    end else if (sample) begin
      log_q[idx_q] <= resp_i;
    end
  end

  assign rd_data = log_q[rd_addr];
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_combi_vector_sequencer.sv
// Self-checking bench for combi_vector_sequencer (DEPTH=16, SETTLE=1).
// Responses come from a behavioural gate model with optional corruption.
module tb_combi_vector_sequencer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [3:0] cfg_vec = '0;
  logic [2:0] cfg_exp = '0;
  logic [4:0] cfg_len = '0;
  logic       start = 1'b0;
  logic [3:0] vec_o;
  logic [2:0] resp_i;
  logic       busy;
  logic       done;
  logic [4:0] err_cnt;
  logic       first_err_vld;
  logic [3:0] first_err_idx;
  logic [3:0] rd_addr = '0;
  logic [2:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] tbl_vec [DEPTH];
  logic [2:0] tbl_exp [DEPTH];
  logic [2:0] corrupt [16];
  bit         fault_en = 1'b0;

  combi_vector_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_vec       (cfg_vec),
    .cfg_exp       (cfg_exp),
    .cfg_len       (cfg_len),
    .start         (start),
    .vec_o         (vec_o),
    .resp_i        (resp_i),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_idx (first_err_idx),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] golden(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {(a & b) | c, a ^ b ^ c ^ d, ~(b | d)};
  endfunction

  always_comb begin
    resp_i = golden(vec_o);
    if (fault_en) resp_i = resp_i ^ corrupt[vec_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [3:0] v, input logic [2:0] e);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a[3:0];
    cfg_vec = v;
    cfg_exp = e;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    tbl_vec[a] = v;
    tbl_exp[a] = e;
  endtask

  task automatic model(input int leff, output int ec, output bit fv,
                       output int fi);
    logic [2:0] r;
    ec = 0;
    fv = 1'b0;
    fi = 0;
    for (int k = 0; k < leff; k++) begin
      r = golden(tbl_vec[k]);
      if (fault_en) r = r ^ corrupt[tbl_vec[k]];
      if (r != tbl_exp[k]) begin
        if (!fv) fi = k;
        fv = 1'b1;
        ec++;
      end
    end
  endtask

  task automatic do_run(input string tag, input int len, input bit inject);
    int leff, done_at, ndone, ec, fi;
    bit fv;
    leff = (len > DEPTH) ? DEPTH : len;
    model(leff, ec, fv, fi);
    @(negedge clk);
    cfg_len = len[4:0];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = -1;
    ndone = 0;
    for (int c = 0; c <= 2 * leff + 6; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (leff > 0 && c % 2 == 1 && (c - 1) / 2 < leff)
        chk({tag, "_vec"}, vec_o, tbl_vec[(c - 1) / 2]);
      if (leff > 0 && c == 1) chk({tag, "_busy"}, busy, 1);
      if (inject && c == 5) begin
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_vec = ~tbl_vec[0];
        cfg_exp = ~tbl_exp[0];
      end
      if (inject && c == 6) begin
        start = 1'b0;
        cfg_we = 1'b0;
      end
    end
    chk({tag, "_done_at"}, done_at, 2 * leff);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_err_cnt"}, err_cnt, ec);
    chk({tag, "_fev"}, first_err_vld, fv);
    if (fv) chk({tag, "_fidx"}, first_err_idx, fi);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [3:0] init_v [10];
    logic [3:0] prev;
    logic [3:0] v;
    logic [2:0] e;
    int ndone;

    init_v = '{4'b0000, 4'b1011, 4'b1000, 4'b0111, 4'b0110,
               4'b1011, 4'b0001, 4'b1010, 4'b1110, 4'b1111};
    for (int i = 0; i < 16; i++) corrupt[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", vec_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fev", first_err_vld, 0);
    chk("rst_fidx", first_err_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) wr(i, init_v[i], golden(init_v[i]));
    do_run("pass10", 10, 1'b0);
    chk("pass10_err0", err_cnt, 0);

    corrupt[4'b0111] = 3'b010;
    corrupt[4'b1010] = 3'b101;
    fault_en = 1'b1;
    do_run("fault10", 10, 1'b0);
    chk("fault10_cnt2", err_cnt, 2);
    chk("fault10_idx3", first_err_idx, 3);
    rd_addr = 4'd3;
    #1;
`ifdef SEQ_RESP_LOG_EN
    chk("log3", rd_data, golden(4'b0111) ^ 3'b010);
`else
    chk("log3_off", rd_data, 0);
`endif
    rd_addr = 4'd2;
    #1;
`ifdef SEQ_RESP_LOG_EN
    chk("log2", rd_data, golden(4'b1000));
`else
    chk("log2_off", rd_data, 0);
`endif
    fault_en = 1'b0;

    prev = vec_o;
    do_run("len0", 0, 1'b0);
    chk("len0_vec_hold", vec_o, prev);

    for (int i = 0; i < DEPTH; i++) begin
      v = 4'($urandom_range(0, 15));
      e = golden(v);
      if ($urandom_range(0, 3) == 0) e = e ^ 3'($urandom_range(1, 7));
      wr(i, v, e);
    end
    do_run("clamp20", 20, 1'b0);

    do_run("illegal", 8, 1'b1);
    do_run("tbl_keep", 1, 1'b0);

    @(negedge clk);
    cfg_len = 5'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_vec4", vec_o, tbl_vec[4]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", vec_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    do_run("after_rst", 10, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        v = 4'($urandom_range(0, 15));
        e = golden(v);
        if ($urandom_range(0, 2) == 0) e = e ^ 3'($urandom_range(1, 7));
        wr($urandom_range(0, DEPTH - 1), v, e);
      end
      do_run("rand", $urandom_range(1, DEPTH), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
